booth_multiplier: RTL and testbench

//  - Fully pipelined signed 32x32 -> 64-bit multiplier using radix-4 (modified) Booth recoding.
//  - Accepts a new operand pair every clock and returns a product every clock after a fixed latency.
//  - Datapath arithmetic leaf with no handshake; the surrounding logic tracks validity by latency.

---
 rtl/booth_multiplier_pkg.sv | 53 +++++
 rtl/booth_pp_gen.sv | 28 ++
 rtl/booth_multiplier.sv | 134 +++++++++++++
 tb/tb_booth_multiplier.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_multiplier_pkg.sv
// Shared constants, Booth digit encodings and the 3:2 carry-save cell used by the
// radix-4 Booth multiplier.
package booth_multiplier_pkg;

    localparam int unsigned MUL_WIDTH   = 32;
    localparam int unsigned MUL_LATENCY = 5;
    localparam int unsigned PP_COUNT    = 17;
    localparam int unsigned PP_WIDTH    = MUL_WIDTH + 2;
    localparam int unsigned PROD_WIDTH  = 2 * MUL_WIDTH;

    // Decoded Booth digit: magnitude select (one/two) and sign.
    typedef struct packed {
        logic neg;
        logic two;
        logic one;
    } booth_sel_t;

    localparam booth_sel_t BoothZero = 3'b000;
    localparam booth_sel_t BoothPos1 = 3'b001;
    localparam booth_sel_t BoothPos2 = 3'b010;
    localparam booth_sel_t BoothNeg1 = 3'b101;
    localparam booth_sel_t BoothNeg2 = 3'b110;

    typedef struct packed {
        logic [PROD_WIDTH-1:0] sum;
        logic [PROD_WIDTH-1:0] carry;
    } csa_t;

    // Window is {b[2j+1], b[2j], b[2j-1]}; 111 is -0 and maps to zero with no negation.
    function automatic booth_sel_t booth_decode(input logic [2:0] win);
        booth_sel_t sel;
        sel = BoothZero;
        case (win)
            3'b001, 3'b010: sel = BoothPos1;
            3'b011:         sel = BoothPos2;
            3'b100:         sel = BoothNeg2;
            3'b101, 3'b110: sel = BoothNeg1;
            default:        sel = BoothZero;
        endcase
        return sel;
    endfunction

    // 3:2 compressor; carry is pre-shifted to its weight, overflow beyond 2*WIDTH is dropped.
    function automatic csa_t csa32(input logic [PROD_WIDTH-1:0] a,
                                   input logic [PROD_WIDTH-1:0] b,
                                   input logic [PROD_WIDTH-1:0] c);
        csa_t r;
        r.sum   = a ^ b ^ c;
        r.carry = ((a & b) | (a & c) | (b & c)) << 1;
        return r;
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Radix-4 Booth encoder and partial-product selector for one digit.
module booth_pp_gen
    import booth_multiplier_pkg::*;
(
    input  logic [2:0]           window,
    input  logic [MUL_WIDTH-1:0] multiplicand,
    output logic [PP_WIDTH-1:0]  pp,
    output logic                 neg
);

    booth_sel_t           sel;
    logic [PP_WIDTH-1:0]  mag;

    // Select |digit| * multiplicand, then one's-complement for negative digits; the +1
    // is carried separately by neg and folded into the reduction tree.
    always_comb begin
        sel = booth_decode(window);
        mag = '0;
        if (sel.one) begin
            mag = {{2{multiplicand[MUL_WIDTH-1]}}, multiplicand};
        end else if (sel.two) begin
            mag = {multiplicand[MUL_WIDTH-1], multiplicand, 1'b0};
        end
        pp  = sel.neg ? ~mag : mag;
        neg = sel.neg;
    end

endmodule

// File: rtl/booth_multiplier.sv
// Fully pipelined signed 32x32 -> 64 radix-4 Booth multiplier, five register stages:
// operands, partial products, CSA to 4 rows, CSA to 2 rows, final carry-propagate add.
module booth_multiplier
    import booth_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [2*WIDTH-1:0] result
);

    localparam int unsigned NumRows = PP_COUNT + 1;

    logic [MUL_WIDTH-1:0]                 a_q, b_q;
    logic [MUL_WIDTH+2:0]                 b_ext;
    logic [PP_COUNT-1:0][PP_WIDTH-1:0]    pp_d, pp_q;
    logic [PP_COUNT-1:0]                  neg_d, neg_q;
    logic [NumRows-1:0][PROD_WIDTH-1:0]   lvl0;
    logic [11:0][PROD_WIDTH-1:0]          lvl1;
    logic [7:0][PROD_WIDTH-1:0]           lvl2;
    logic [5:0][PROD_WIDTH-1:0]           lvl3;
    logic [3:0][PROD_WIDTH-1:0]           rows_d, rows_q;
    logic [PROD_WIDTH-1:0]                sum_d, sum_q, carry_d, carry_q;

    // Stage 1: capture operands.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= multiplicand;
            b_q <= multiplier;
        end
    end

    // Implicit zero below bit 0, two sign bits on top: 17 overlapping 3-bit windows.
    assign b_ext = {{2{b_q[MUL_WIDTH-1]}}, b_q, 1'b0};

    for (genvar j = 0; j < PP_COUNT; j++) begin : g_pp
        booth_pp_gen u_pp_gen (
            .window      (b_ext[2*j+2:2*j]),
            .multiplicand(a_q),
            .pp          (pp_d[j]),
            .neg         (neg_d[j])
        );
    end

    // Stage 2: register partial products and their negation-correction bits.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pp_q  <= '0;
            neg_q <= '0;
        end else begin
            pp_q  <= pp_d;
            neg_q <= neg_d;
        end
    end

    // Align partial products, gather correction bits into one row, compress 18 -> 4 rows.
    always_comb begin
        csa_t t;
        t = '0;
        lvl0 = '0;
        for (int j = 0; j < PP_COUNT; j++) begin
            lvl0[j] = {{(PROD_WIDTH-PP_WIDTH){pp_q[j][PP_WIDTH-1]}}, pp_q[j]} << (2 * j);
            // Correction bits sit at distinct even weights, so one row holds them all.
            lvl0[PP_COUNT][2*j] = neg_q[j];
        end
        for (int i = 0; i < 6; i++) begin
            t = csa32(lvl0[3*i], lvl0[3*i+1], lvl0[3*i+2]);
            lvl1[2*i]   = t.sum;
            lvl1[2*i+1] = t.carry;
        end
        for (int i = 0; i < 4; i++) begin
            t = csa32(lvl1[3*i], lvl1[3*i+1], lvl1[3*i+2]);
            lvl2[2*i]   = t.sum;
            lvl2[2*i+1] = t.carry;
        end
        for (int i = 0; i < 2; i++) begin
            t = csa32(lvl2[3*i], lvl2[3*i+1], lvl2[3*i+2]);
            lvl3[2*i]   = t.sum;
            lvl3[2*i+1] = t.carry;
        end
        lvl3[4] = lvl2[6];
        lvl3[5] = lvl2[7];
        for (int i = 0; i < 2; i++) begin
            t = csa32(lvl3[3*i], lvl3[3*i+1], lvl3[3*i+2]);
            rows_d[2*i]   = t.sum;
            rows_d[2*i+1] = t.carry;
        end
    end

    // Stage 3: register the four remaining rows.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rows_q <= '0;
        end else begin
            rows_q <= rows_d;
        end
    end

    // Compress 4 -> 2 rows.
    always_comb begin
        csa_t t0, t1;
        t0      = csa32(rows_q[0], rows_q[1], rows_q[2]);
        t1      = csa32(t0.sum, t0.carry, rows_q[3]);
        sum_d   = t1.sum;
        carry_d = t1.carry;
    end

    // Stage 4: register sum and carry vectors.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sum_q   <= '0;
            carry_q <= '0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    // Stage 5: final carry-propagate add into the result register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            result <= '0;
        end else begin
            result <= sum_q + carry_q;
        end
    end

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier: expected products are queued with the cycle
// at which they are due on result and compared at the falling edge of that cycle.
module tb_booth_multiplier;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [31:0] multiplicand = '0;
    logic [31:0] multiplier = '0;
    logic [63:0] result;

    typedef struct {
        int unsigned due;
        logic [63:0] val;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    booth_multiplier dut (
        .clk         (clk),
        .rstn        (rstn),
        .multiplicand(multiplicand),
        .multiplier  (multiplier),
        .result      (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] golden(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        return sa * sb;
    endfunction

    function automatic logic [31:0] pick_operand();
        int unsigned sel;
        sel = $urandom_range(0, 7);
        if (sel == 0) return 32'h0000_0000;
        if (sel == 1) return 32'hFFFF_FFFF;
        if (sel == 2) return 32'h8000_0000;
        return $urandom;
    endfunction

    // Apply a pair (clock low) and queue its product, due five edges later.
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        exp_t e;
        multiplicand = a;
        multiplier   = b;
        e.due        = cyc + 5;
        e.val        = exp;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        exp_t e;
        rstn = 1'b0;
        #1;
        checks++;
        if (result !== 64'h0)
            $display("FAIL reset_async: result=%h expected=%h", result, 64'h0);
        if (result !== 64'h0) errors++;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            multiplicand = $urandom;
            multiplier   = $urandom;
            tick();
            checks++;
            if (result !== 64'h0) begin
                errors++;
                $display("FAIL reset_hold: result=%h expected=%h cycle=%0d", result, 64'h0, cyc);
            end
        end
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            drive(a, b, golden(a, b));
            tick();
            checks++;
            if (sb_q.size() != 0 && sb_q[0].due == cyc) begin
                e = sb_q.pop_front();
                if (result !== e.val) begin
                    errors++;
                    $display("FAIL post_reset: result=%h expected=%h cycle=%0d", result, e.val, cyc);
                end
            end else if (result !== 64'h0) begin
                errors++;
                $display("FAIL reset_quiet: result=%h expected=%h cycle=%0d", result, 64'h0, cyc);
            end
        end
    endtask

    task automatic test_corners();
        logic [31:0] ta[6] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF,
                               32'h8000_0000, 32'h1234_5678, 32'h8000_0000};
        logic [31:0] tb[6] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0001,
                               32'hFFFF_FFFF, 32'h0000_0000, 32'h7FFF_FFFF};
        logic [63:0] tp[6] = '{64'h3FFF_FFFF_0000_0001, 64'h4000_0000_0000_0000,
                               64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_8000_0000,
                               64'h0000_0000_0000_0000, 64'hC000_0000_8000_0000};
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            drive(ta[i], tb[i], tp[i]);
            tick();
            if (sb_q.size() != 0 && sb_q[0].due == cyc) begin
                e = sb_q.pop_front();
                checks++;
                if (result !== e.val) begin
                    errors++;
                    $display("FAIL corners: result=%h expected=%h cycle=%0d", result, e.val, cyc);
                end
            end
        end
    endtask

    task automatic test_booth_patterns();
        logic [31:0] pa[2] = '{32'hAAAA_AAAA, 32'h5555_5555};
        logic [31:0] pb[2] = '{32'h5555_5555, 32'hAAAA_AAAA};
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            drive(pa[i], pb[i], golden(pa[i], pb[i]));
            tick();
            if (sb_q.size() != 0 && sb_q[0].due == cyc) begin
                e = sb_q.pop_front();
                checks++;
                if (result !== e.val) begin
                    errors++;
                    $display("FAIL booth_pattern: result=%h expected=%h cycle=%0d",
                             result, e.val, cyc);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            drive(a, b, golden(a, b));
            tick();
            if (sb_q.size() != 0 && sb_q[0].due == cyc) begin
                e = sb_q.pop_front();
                checks++;
                if (result !== e.val) begin
                    errors++;
                    $display("FAIL back_to_back: result=%h expected=%h cycle=%0d",
                             result, e.val, cyc);
                end
            end
        end
    endtask

    task automatic test_midstream_reset();
        exp_t e;
        bit   after_rst = 1'b0;
        for (int i = 0; i < 14; i++) begin
            logic [31:0] a, b;
            if (i == 5) begin
                // Drop reset while the clock is low, hold it across one rising edge.
                #2 rstn = 1'b0;
                #1;
                checks++;
                if (result !== 64'h0) begin
                    errors++;
                    $display("FAIL midreset_async: result=%h expected=%h", result, 64'h0);
                end
                sb_q.delete();
                @(posedge clk);
                @(negedge clk);
                rstn = 1'b1;
                after_rst = 1'b1;
            end
            a = pick_operand();
            b = pick_operand();
            drive(a, b, golden(a, b));
            tick();
            if (sb_q.size() != 0 && sb_q[0].due == cyc) begin
                e = sb_q.pop_front();
                checks++;
                if (result !== e.val) begin
                    errors++;
                    $display("FAIL midreset_stream: result=%h expected=%h cycle=%0d",
                             result, e.val, cyc);
                end
            end else if (after_rst) begin
                checks++;
                if (result !== 64'h0) begin
                    errors++;
                    $display("FAIL midreset_quiet: result=%h expected=%h cycle=%0d",
                             result, 64'h0, cyc);
                end
            end
        end
    endtask

    task automatic test_soak();
        exp_t e;
        for (int i = 0; i < 10000 + 5; i++) begin
            if (i < 10000) begin
                logic [31:0] a, b;
                a = pick_operand();
                b = pick_operand();
                drive(a, b, golden(a, b));
            end else begin
                multiplicand = '0;
                multiplier   = '0;
            end
            tick();
            if (sb_q.size() != 0 && sb_q[0].due == cyc) begin
                e = sb_q.pop_front();
                checks++;
                if (result !== e.val) begin
                    errors++;
                    $display("FAIL soak: result=%h expected=%h cycle=%0d", result, e.val, cyc);
                end
            end
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d expected=0", sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_corners();
        test_booth_patterns();
        test_back_to_back();
        test_midstream_reset();
        test_soak();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
